// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost mode scheduler.
// Mode encoding, per-ghost/top state enums, phase schedule table and timer widths.
package ghost_pkg;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'b00,
        MODE_CHASE   = 2'b01,
        MODE_FRIGHT  = 2'b10,
        MODE_EATEN   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        GS_NORMAL = 2'b00,
        GS_FRIGHT = 2'b01,
        GS_EATEN  = 2'b10
    } ghost_state_t;

    typedef enum logic {
        TOP_IDLE = 1'b0,
        TOP_RUN  = 1'b1
    } top_state_t;

    localparam int PHASE_W    = 11;
    localparam int FRIGHT_W   = 9;
    localparam int NUM_PHASES = 8;

    // Phase 7 is loaded with zero so its timer can never reach the expiry value.
    localparam logic [PHASE_W-1:0] PHASE_TICKS [0:NUM_PHASES-1] = '{
        11'd420, 11'd1200, 11'd420, 11'd1200,
        11'd300, 11'd1200, 11'd300, 11'd0
    };

    function automatic mode_t mode_of(input ghost_state_t gs, input logic [2:0] phase);
        mode_t m;
        case (gs)
            GS_FRIGHT: m = MODE_FRIGHT;
            GS_EATEN:  m = MODE_EATEN;
            default:   m = phase[0] ? MODE_CHASE : MODE_SCATTER;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_tick_timer.sv
// Loadable down-counter advancing on frame ticks, with hold and zero/one flags.
// Latency: count updates one cycle after load/tick; no backpressure (load beats tick).
module tick_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         hold,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !hold && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == W'(1));

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Sequences scatter/chase/fright/eaten modes and reverse pulses for all ghosts.
// Latency: every output reflects an input event one cycle later; no backpressure, pulses never stall.
// Optional: PHASE_SKIP_EN adds a skip_phase debug input that forces a phase expiry.
module ghost_mode_scheduler
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS    = 2,
    parameter int TICKS_PER_SEC = 60,
    parameter int FRIGHT_SEC    = 6,
    parameter int FLASH_SEC     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    game_start,
    input  logic                    pause,
    input  logic                    power_pellet,
    input  logic [NUM_GHOSTS-1:0]   ghost_eaten,
    input  logic [NUM_GHOSTS-1:0]   ghost_home,
`ifdef PHASE_SKIP_EN
    input  logic                    skip_phase,
`endif
    output logic [2*NUM_GHOSTS-1:0] ghost_mode,
    output logic [NUM_GHOSTS-1:0]   reverse,
    output logic                    fright_flash,
    output logic [2:0]              phase_idx,
    output logic [1:0]              eat_combo
);

    localparam logic [FRIGHT_W-1:0] FRIGHT_TICKS = FRIGHT_W'(FRIGHT_SEC * TICKS_PER_SEC);
    localparam logic [FRIGHT_W-1:0] FLASH_TICKS  = FRIGHT_W'(FLASH_SEC * TICKS_PER_SEC);

    top_state_t   state_q, state_d;
    ghost_state_t gs_q [NUM_GHOSTS];
    ghost_state_t gs_d [NUM_GHOSTS];

    logic [2:0]              phase_d, phase_nxt;
    logic [2*NUM_GHOSTS-1:0] mode_d;
    logic [NUM_GHOSTS-1:0]   rev_d;
    logic [1:0]              combo_d;

    logic run, tick_live, pellet;
    logic phase_expire, skip_req, advance, fright_expire;
    logic phase_load, phase_hold, fright_hold;
    logic [PHASE_W-1:0]  phase_load_val;
    logic [PHASE_W-1:0]  phase_cnt_unused;
    logic [FRIGHT_W-1:0] fright_cnt;
    logic phase_zero, phase_one, fright_zero, fright_one;

    assign run       = (state_q == TOP_RUN);
    assign tick_live = tick && !pause;
    assign pellet    = run && power_pellet;
    assign phase_nxt = phase_idx + 3'd1;

    // A pellet on the expiry tick wins: the phase timer is held at 1.
    assign phase_expire  = run && tick_live && fright_zero && !power_pellet && phase_one;
    assign fright_expire = run && tick_live && fright_one && !power_pellet;

`ifdef PHASE_SKIP_EN
    assign skip_req = skip_phase && run && fright_zero && !phase_zero && !power_pellet;
`else
    assign skip_req = 1'b0;
`endif

    assign advance        = phase_expire || skip_req;
    assign phase_load     = (!run && game_start) || advance;
    assign phase_load_val = run ? PHASE_TICKS[phase_nxt] : PHASE_TICKS[0];
    assign phase_hold     = !run || pause || !fright_zero || power_pellet || phase_zero;
    assign fright_hold    = !run || pause;

    tick_timer #(.W(PHASE_W)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .hold     (phase_hold),
        .load     (phase_load),
        .load_val (phase_load_val),
        .count    (phase_cnt_unused),
        .is_zero  (phase_zero),
        .is_one   (phase_one)
    );

    tick_timer #(.W(FRIGHT_W)) u_fright_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .hold     (fright_hold),
        .load     (pellet),
        .load_val (FRIGHT_TICKS),
        .count    (fright_cnt),
        .is_zero  (fright_zero),
        .is_one   (fright_one)
    );

    // Flash is a pure decode of the fright counter register.
    assign fright_flash = !fright_zero && (fright_cnt <= FLASH_TICKS);

    always_comb begin
        state_d = state_q;
        if ((state_q == TOP_IDLE) && game_start) begin
            state_d = TOP_RUN;
        end
    end

    // Per-ghost transitions are all judged against the pre-cycle state.
    always_comb begin
        int unsigned eaten_cnt;
        int unsigned combo_sum;
        eaten_cnt = 0;
        phase_d   = advance ? phase_nxt : phase_idx;
        mode_d    = '0;
        rev_d     = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            gs_d[i] = gs_q[i];
            if (run) begin
                case (gs_q[i])
                    GS_NORMAL: begin
                        if (power_pellet) begin
                            gs_d[i]  = GS_FRIGHT;
                            rev_d[i] = 1'b1;
                        end else if (advance) begin
                            rev_d[i] = 1'b1;
                        end
                    end
                    GS_FRIGHT: begin
                        if (ghost_eaten[i]) begin
                            gs_d[i]   = GS_EATEN;
                            eaten_cnt = eaten_cnt + 1;
                        end else if (power_pellet) begin
                            rev_d[i] = 1'b1;
                        end else if (fright_expire) begin
                            gs_d[i] = GS_NORMAL;
                        end
                    end
                    GS_EATEN: begin
                        if (ghost_home[i]) begin
                            gs_d[i] = GS_NORMAL;
                        end
                    end
                    default: gs_d[i] = GS_NORMAL;
                endcase
            end
            mode_d[2*i +: 2] = mode_of(gs_d[i], phase_d);
        end
        combo_sum = (pellet ? 32'd0 : 32'(eat_combo)) + eaten_cnt;
        combo_d   = (combo_sum > 32'd3) ? 2'd3 : combo_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TOP_IDLE;
            phase_idx  <= 3'd0;
            eat_combo  <= 2'd0;
            reverse    <= '0;
            ghost_mode <= '0;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                gs_q[i] <= GS_NORMAL;
            end
        end else begin
            state_q    <= state_d;
            phase_idx  <= phase_d;
            eat_combo  <= combo_d;
            reverse    <= rev_d;
            ghost_mode <= mode_d;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                gs_q[i] <= gs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler: schedule, fright, eating, simultaneous events, pause and reset.
module tb_ghost_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       game_start;
    logic       pause;
    logic       power_pellet;
    logic [1:0] ghost_eaten;
    logic [1:0] ghost_home;
    logic [3:0] ghost_mode;
    logic [1:0] reverse;
    logic       fright_flash;
    logic [2:0] phase_idx;
    logic [1:0] eat_combo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ghost_mode_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .game_start   (game_start),
        .pause        (pause),
        .power_pellet (power_pellet),
        .ghost_eaten  (ghost_eaten),
        .ghost_home   (ghost_home),
        .ghost_mode   (ghost_mode),
        .reverse      (reverse),
        .fright_flash (fright_flash),
        .phase_idx    (phase_idx),
        .eat_combo    (eat_combo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        for (int k = 0; k < n; k++) step();
        tick = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick = 1'b0; game_start = 1'b0; pause = 1'b0;
        power_pellet = 1'b0; ghost_eaten = 2'b00; ghost_home = 2'b00;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic start_game();
        game_start = 1'b1; step(); game_start = 1'b0;
    endtask

    task automatic pellet_pulse();
        power_pellet = 1'b1; step(); power_pellet = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (ghost_mode !== 4'b0000) begin errors++; $display("FAIL reset_mode: got %b want 0000", ghost_mode); end
        checks++; if (reverse !== 2'b00) begin errors++; $display("FAIL reset_reverse: got %b want 00", reverse); end
        checks++; if (fright_flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %b want 0", fright_flash); end
        checks++; if (phase_idx !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase_idx); end
        checks++; if (eat_combo !== 2'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", eat_combo); end
    endtask

    task automatic test_schedule();
        reset_dut();
        start_game();
        checks++; if (ghost_mode !== 4'b0000) begin errors++; $display("FAIL sched_start_mode: got %b want 0000", ghost_mode); end
        run_ticks(419);
        checks++; if (phase_idx !== 3'd0) begin errors++; $display("FAIL sched_p0_hold: got %0d want 0", phase_idx); end
        checks++; if (reverse !== 2'b00) begin errors++; $display("FAIL sched_no_rev: got %b want 00", reverse); end
        run_ticks(1);
        checks++; if (phase_idx !== 3'd1) begin errors++; $display("FAIL sched_p1: got %0d want 1", phase_idx); end
        checks++; if (ghost_mode !== 4'b0101) begin errors++; $display("FAIL sched_p1_mode: got %b want 0101", ghost_mode); end
        checks++; if (reverse !== 2'b11) begin errors++; $display("FAIL sched_p1_rev: got %b want 11", reverse); end
        step();
        checks++; if (reverse !== 2'b00) begin errors++; $display("FAIL sched_rev_1cyc: got %b want 00", reverse); end
        // Phases 1..6 last 1200+420+1200+300+1200+300 = 4620 ticks.
        run_ticks(4619);
        checks++; if (phase_idx !== 3'd6) begin errors++; $display("FAIL sched_p6: got %0d want 6", phase_idx); end
        checks++; if (ghost_mode !== 4'b0000) begin errors++; $display("FAIL sched_p6_mode: got %b want 0000", ghost_mode); end
        run_ticks(1);
        checks++; if (phase_idx !== 3'd7) begin errors++; $display("FAIL sched_p7: got %0d want 7", phase_idx); end
        checks++; if (reverse !== 2'b11) begin errors++; $display("FAIL sched_p7_rev: got %b want 11", reverse); end
        run_ticks(5000);
        checks++; if (phase_idx !== 3'd7) begin errors++; $display("FAIL sched_p7_stay: got %0d want 7", phase_idx); end
        checks++; if (ghost_mode !== 4'b0101) begin errors++; $display("FAIL sched_p7_mode: got %b want 0101", ghost_mode); end
        checks++; if (reverse !== 2'b00) begin errors++; $display("FAIL sched_p7_norev: got %b want 00", reverse); end
    endtask

    task automatic test_fright();
        reset_dut();
        start_game();
        run_ticks(100);
        pellet_pulse();
        checks++; if (ghost_mode !== 4'b1010) begin errors++; $display("FAIL fr_mode: got %b want 1010", ghost_mode); end
        checks++; if (reverse !== 2'b11) begin errors++; $display("FAIL fr_rev: got %b want 11", reverse); end
        checks++; if (dut.u_fright_timer.count !== 9'd360) begin errors++; $display("FAIL fr_timer: got %0d want 360", dut.u_fright_timer.count); end
        run_ticks(239);
        checks++; if (fright_flash !== 1'b0) begin errors++; $display("FAIL fr_flash_early: got %b want 0", fright_flash); end
        run_ticks(1);
        checks++; if (fright_flash !== 1'b1) begin errors++; $display("FAIL fr_flash_rise: got %b want 1", fright_flash); end
        run_ticks(119);
        checks++; if (ghost_mode !== 4'b1010) begin errors++; $display("FAIL fr_last_tick_mode: got %b want 1010", ghost_mode); end
        run_ticks(1);
        checks++; if (ghost_mode !== 4'b0000) begin errors++; $display("FAIL fr_end_mode: got %b want 0000", ghost_mode); end
        checks++; if (fright_flash !== 1'b0) begin errors++; $display("FAIL fr_end_flash: got %b want 0", fright_flash); end
        checks++; if (reverse !== 2'b00) begin errors++; $display("FAIL fr_end_norev: got %b want 00", reverse); end
        checks++; if (dut.u_phase_timer.count !== 11'd320) begin errors++; $display("FAIL fr_phase_held: got %0d want 320", dut.u_phase_timer.count); end
        run_ticks(319);
        checks++; if (phase_idx !== 3'd0) begin errors++; $display("FAIL fr_resume_p0: got %0d want 0", phase_idx); end
        run_ticks(1);
        checks++; if (phase_idx !== 3'd1) begin errors++; $display("FAIL fr_resume_p1: got %0d want 1", phase_idx); end
    endtask

    task automatic test_eat_combo();
        reset_dut();
        start_game();
        pellet_pulse();
        ghost_eaten = 2'b01; step(); ghost_eaten = 2'b00;
        checks++; if (ghost_mode !== 4'b1011) begin errors++; $display("FAIL eat0_mode: got %b want 1011", ghost_mode); end
        checks++; if (eat_combo !== 2'd1) begin errors++; $display("FAIL eat0_combo: got %0d want 1", eat_combo); end
        ghost_eaten = 2'b10; step(); ghost_eaten = 2'b00;
        checks++; if (ghost_mode !== 4'b1111) begin errors++; $display("FAIL eat1_mode: got %b want 1111", ghost_mode); end
        checks++; if (eat_combo !== 2'd2) begin errors++; $display("FAIL eat1_combo: got %0d want 2", eat_combo); end
        ghost_home = 2'b01; step(); ghost_home = 2'b00;
        checks++; if (ghost_mode !== 4'b1100) begin errors++; $display("FAIL home0_mode: got %b want 1100", ghost_mode); end
        ghost_eaten = 2'b01; step(); ghost_eaten = 2'b00;
        checks++; if (ghost_mode !== 4'b1100) begin errors++; $display("FAIL eat_normal_ignored: got %b want 1100", ghost_mode); end
        checks++; if (eat_combo !== 2'd2) begin errors++; $display("FAIL eat_normal_combo: got %0d want 2", eat_combo); end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        start_game();
        pellet_pulse();
        run_ticks(5);
        power_pellet = 1'b1; ghost_eaten = 2'b01; step();
        power_pellet = 1'b0; ghost_eaten = 2'b00;
        checks++; if (ghost_mode !== 4'b1011) begin errors++; $display("FAIL sim_eat_pellet_mode: got %b want 1011", ghost_mode); end
        checks++; if (dut.u_fright_timer.count !== 9'd360) begin errors++; $display("FAIL sim_timer: got %0d want 360", dut.u_fright_timer.count); end
        checks++; if (eat_combo !== 2'd1) begin errors++; $display("FAIL sim_combo: got %0d want 1", eat_combo); end
        checks++; if (reverse !== 2'b10) begin errors++; $display("FAIL sim_rev: got %b want 10", reverse); end
        power_pellet = 1'b1; ghost_home = 2'b01; step();
        power_pellet = 1'b0; ghost_home = 2'b00;
        checks++; if (ghost_mode !== 4'b1000) begin errors++; $display("FAIL sim_home_pellet: got %b want 1000", ghost_mode); end
        checks++; if (eat_combo !== 2'd0) begin errors++; $display("FAIL sim_combo_clear: got %0d want 0", eat_combo); end
        reset_dut();
        start_game();
        run_ticks(419);
        tick = 1'b1; power_pellet = 1'b1; step();
        tick = 1'b0; power_pellet = 1'b0;
        checks++; if (phase_idx !== 3'd0) begin errors++; $display("FAIL sim_expiry_pellet_phase: got %0d want 0", phase_idx); end
        checks++; if (dut.u_phase_timer.count !== 11'd1) begin errors++; $display("FAIL sim_expiry_pellet_timer: got %0d want 1", dut.u_phase_timer.count); end
    endtask

    task automatic test_pause_reset();
        reset_dut();
        start_game();
        run_ticks(50);
        pause = 1'b1;
        run_ticks(500);
        checks++; if (dut.u_phase_timer.count !== 11'd370) begin errors++; $display("FAIL pause_phase_timer: got %0d want 370", dut.u_phase_timer.count); end
        pellet_pulse();
        checks++; if (ghost_mode !== 4'b1010) begin errors++; $display("FAIL pause_pellet_mode: got %b want 1010", ghost_mode); end
        run_ticks(30);
        checks++; if (dut.u_fright_timer.count !== 9'd360) begin errors++; $display("FAIL pause_fright_timer: got %0d want 360", dut.u_fright_timer.count); end
        pause = 1'b0;
        run_ticks(10);
        checks++; if (dut.u_fright_timer.count !== 9'd350) begin errors++; $display("FAIL unpause_fright_timer: got %0d want 350", dut.u_fright_timer.count); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (ghost_mode !== 4'b0000) begin errors++; $display("FAIL rst_mid_mode: got %b want 0000", ghost_mode); end
        checks++; if (dut.u_fright_timer.count !== 9'd0) begin errors++; $display("FAIL rst_mid_fright: got %0d want 0", dut.u_fright_timer.count); end
        checks++; if (fright_flash !== 1'b0) begin errors++; $display("FAIL rst_mid_flash: got %b want 0", fright_flash); end
        run_ticks(20);
        pellet_pulse();
        checks++; if (ghost_mode !== 4'b0000) begin errors++; $display("FAIL idle_pellet_ignored: got %b want 0000", ghost_mode); end
        checks++; if (dut.u_phase_timer.count !== 11'd0) begin errors++; $display("FAIL idle_phase_timer: got %0d want 0", dut.u_phase_timer.count); end
        checks++; if (reverse !== 2'b00) begin errors++; $display("FAIL idle_reverse: got %b want 00", reverse); end
        start_game();
        checks++; if (dut.u_phase_timer.count !== 11'd420) begin errors++; $display("FAIL restart_timer: got %0d want 420", dut.u_phase_timer.count); end
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_fright();
        test_eat_combo();
        test_simultaneous();
        test_pause_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
